demux1x2_8bits_rx: RTL and testbench

//  - Receive-side byte unstriper. Takes the single interleaved byte stream produced by the TX 2:1 lane mux and splits it back into lane 0 / lane 1.
//  - Even slots go to lane 0 and odd slots go to lane 1. Slot phase is recovered from the first valid byte.
//  - Completed pairs are emitted together, time-aligned, on registered outputs.

---
 rtl/phy_rx_pkg.sv | 15 +
 rtl/demux1x2_8bits_rx.sv | 114 +++++++++++
 tb/tb_demux1x2_8bits_rx.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/phy_rx_pkg.sv
// Shared definitions for the receive-side lane unstriper.
package phy_rx_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_LOSS_LIMIT = 4;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/demux1x2_8bits_rx.sv
// Splits the interleaved TX byte stream back into lane 0 / lane 1, recovering
// slot phase from the first valid byte and emitting completed pairs aligned.
module demux1x2_8bits_rx
    import phy_rx_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LOSS_LIMIT = DEF_LOSS_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             locked
);

    localparam int unsigned CNT_W = $clog2(LOSS_LIMIT + 1);

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic [WIDTH-1:0]   stage0_q, stage0_d;
    logic               stage0_v_q, stage0_v_d;
    logic [CNT_W-1:0]   inv_cnt_q, inv_cnt_d;
    logic [CNT_W-1:0]   inv_next;
    logic [WIDTH-1:0]   dout0_q, dout0_d;
    logic [WIDTH-1:0]   dout1_q, dout1_d;
    logic               vout0_q, vout0_d;
    logic               vout1_q, vout1_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HUNT;
            sel_q      <= LANE0;
            stage0_q   <= '0;
            stage0_v_q <= 1'b0;
            inv_cnt_q  <= '0;
            dout0_q    <= '0;
            dout1_q    <= '0;
            vout0_q    <= 1'b0;
            vout1_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            stage0_q   <= stage0_d;
            stage0_v_q <= stage0_v_d;
            inv_cnt_q  <= inv_cnt_d;
            dout0_q    <= dout0_d;
            dout1_q    <= dout1_d;
            vout0_q    <= vout0_d;
            vout1_q    <= vout1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        stage0_d   = stage0_q;
        stage0_v_d = stage0_v_q;
        inv_cnt_d  = inv_cnt_q;
        dout0_d    = dout0_q;
        dout1_d    = dout1_q;
        vout0_d    = 1'b0;
        vout1_d    = 1'b0;
        inv_next   = (inv_cnt_q == CNT_W'(LOSS_LIMIT)) ? inv_cnt_q : inv_cnt_q + CNT_W'(1);

        case (state_q)
            ST_HUNT: begin
                sel_d     = LANE0;
                inv_cnt_d = '0;
                // First valid byte defines slot phase: it is a lane 0 byte.
                if (valid_in) begin
                    stage0_d   = data_in;
                    stage0_v_d = 1'b1;
                    sel_d      = LANE1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                sel_d = ~sel_q;
                if (sel_q == LANE0) begin
                    stage0_d   = data_in;
                    stage0_v_d = valid_in;
                end else begin
                    vout0_d = stage0_v_q;
                    vout1_d = valid_in;
                    if (stage0_v_q) dout0_d = stage0_q;
                    if (valid_in)   dout1_d = data_in;
                end

                // A long enough idle gap means the TX phase can no longer be trusted.
                if (valid_in) begin
                    inv_cnt_d = '0;
                end else begin
                    inv_cnt_d = inv_next;
                    if (inv_next == CNT_W'(LOSS_LIMIT)) begin
                        state_d    = ST_HUNT;
                        sel_d      = LANE0;
                        stage0_v_d = 1'b0;
                    end
                end
            end
        endcase
    end

    assign data_out0  = dout0_q;
    assign data_out1  = dout1_q;
    assign valid_out0 = vout0_q;
    assign valid_out1 = vout1_q;
    assign locked     = (state_q == ST_RUN);

endmodule

// File: tb/tb_demux1x2_8bits_rx.sv
// Scoreboard bench for the lane unstriper: a stream-level reference model queues
// expected lock state and output pairs; an independent monitor checks the DUT.
module tb_demux1x2_8bits_rx;

    localparam int unsigned W  = 8;
    localparam int          LL = 4;

    typedef struct {
        int         idx;
        logic       v0;
        logic       v1;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
    } pair_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic [W-1:0] data_out0, data_out1;
    logic         valid_out0, valid_out1, locked;

    demux1x2_8bits_rx dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    pair_t pair_q[$];
    logic  lock_q[$];
    int    drv_idx = 0;
    int    mon_idx = 0;

    // Reference model state: stream position relative to the recovered phase.
    logic         m_locked, m_odd, m_pv;
    logic [W-1:0] m_pd, m_last0, m_last1;
    int           m_idle;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 1'b0; m_odd = 1'b0; m_pv = 1'b0; m_pd = '0;
        m_last0 = '0; m_last1 = '0; m_idle = 0;
        pair_q.delete();
        lock_q.delete();
        drv_idx = 0;
        mon_idx = 0;
    endfunction

    // One input cycle of the byte stream; queues what the next edge must show.
    function automatic void model_step(input logic v, input logic [W-1:0] d);
        pair_t p;
        if (!m_locked) begin
            if (v) begin
                m_locked = 1'b1; m_odd = 1'b1; m_pv = 1'b1; m_pd = d; m_idle = 0;
            end
        end else begin
            if (m_odd) begin
                if (m_pv) m_last0 = m_pd;
                if (v)    m_last1 = d;
                if (m_pv || v) begin
                    p.idx = drv_idx; p.v0 = m_pv; p.v1 = v; p.d0 = m_last0; p.d1 = m_last1;
                    pair_q.push_back(p);
                end
                m_pv = 1'b0;
            end else begin
                m_pv = v;
                m_pd = d;
            end
            m_odd  = ~m_odd;
            m_idle = v ? 0 : m_idle + 1;
            if (m_idle == LL) begin
                m_locked = 1'b0; m_pv = 1'b0; m_idle = 0; m_odd = 1'b0;
            end
        end
        lock_q.push_back(m_locked);
        drv_idx++;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        model_step(v, d);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_dout0"},  32'(data_out0), 32'h0);
        check({tag, "_dout1"},  32'(data_out1), 32'h0);
        check({tag, "_vout0"},  32'(valid_out0), 32'h0);
        check({tag, "_vout1"},  32'(valid_out1), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
    endtask

    // Reset asserted between clock edges, released on a falling edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset    = 1'b0;
        valid_in = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: sample after each rising edge, independent of the stimulus.
    initial begin : monitor
        pair_t p;
        logic  el;
        int    e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && lock_q.size() > 0) begin
                el = lock_q.pop_front();
                check("locked", 32'(locked), 32'(el));
                e = mon_idx;
                mon_idx++;
                if (valid_out0 || valid_out1) begin
                    if (pair_q.size() == 0 || pair_q[0].idx != e) begin
                        check("unexpected_valid", 32'({valid_out0, valid_out1}), 32'h0);
                    end else begin
                        p = pair_q.pop_front();
                        check("valid_out0", 32'(valid_out0), 32'(p.v0));
                        check("valid_out1", 32'(valid_out1), 32'(p.v1));
                        check("data_out0",  32'(data_out0),  32'(p.d0));
                        check("data_out1",  32'(data_out1),  32'(p.d1));
                    end
                end else if (pair_q.size() > 0 && pair_q[0].idx == e) begin
                    p = pair_q.pop_front();
                    check("missing_pair", 32'({valid_out0, valid_out1}), 32'({p.v0, p.v1}));
                end
            end else if (valid_out0 || valid_out1) begin
                check("stray_valid", 32'({valid_out0, valid_out1}), 32'h0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic         v0, v1;
        logic [W-1:0] d0, d1;

        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        model_reset();
        #1;
        check_zero_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Basic pairing
        drive(1'b1, 8'hA1); drive(1'b1, 8'hB2);
        drive(1'b1, 8'hC3); drive(1'b1, 8'hD4);
        drive(1'b0, 8'h00); drive(1'b0, 8'h00);

        // Half pairs: lane 0 only, then lane 1 only
        drive(1'b1, 8'h11); drive(1'b0, 8'hEE);
        drive(1'b0, 8'hEE); drive(1'b1, 8'h22);

        // Three idle cycles keep lock, four drop it, then relock
        drive(1'b0, 8'h00); drive(1'b0, 8'h00); drive(1'b0, 8'h00);
        drive(1'b1, 8'h33);
        repeat (4) drive(1'b0, 8'h00);
        drive(1'b1, 8'h77); drive(1'b1, 8'h88);
        drive(1'b0, 8'h00); drive(1'b0, 8'h00);

        // Phase recovery after an odd idle count
        async_reset();
        repeat (3) drive(1'b0, 8'h00);
        drive(1'b1, 8'h55); drive(1'b1, 8'h66);
        drive(1'b0, 8'h00); drive(1'b0, 8'h00);

        // Stage a lane 0 byte, then reset mid-pair; it must never appear
        drive(1'b1, 8'h99);
        async_reset();
        repeat (4) drive(1'b0, 8'h00);

        // Round trip behind a modelled TX 2:1 mux
        for (int i = 0; i < 500; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            d0 = W'($urandom);
            d1 = W'($urandom);
            drive(v0, d0);
            drive(v1, d1);
        end
        repeat (4) drive(1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);

        check("drain_pairs", 32'(pair_q.size()), 32'h0);
        check("drain_lock",  32'(lock_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
